simon_stream_io: RTL
====================

Name: simon_stream_io

Overview:
- Parametrised successor to the chip's fixed nibble/byte load-and-unload path around the Simon 32/64 core.
- Deserialises key and text from narrow pins with an input qualifier, and supports key reuse.
- Launches the external cipher core with a timeout watchdog, then streams result and text-echo out under ready/valid backpressure.
- Sits between the pad ring and the cipher core.

Parameters:
- DATA_W, 32, block width (core text/result)
- KEY_W, 64, key width
- KEY_IN_W, 8, key bits per input beat; must divide KEY_W
- TXT_IN_W, 4, text bits per input beat; must divide DATA_W
- OUT_W, 4, output bits per beat; must divide DATA_W
- TIMEOUT, 255, max cycles waiting for core_done

Ports:
- clk  in  1  single clock, rising edge
- reset  in  1  asynchronous, active-low reset
- start  in  1  one-cycle pulse begins a transaction (IDLE only)
- keep_key  in  1  sampled with start; 1 = reuse stored key, load text only
- mode_in  in  1  sampled with start; 0 encrypt, 1 decrypt
- in_valid  in  1  qualifies key_in/txt_in beats during LOAD
- key_in  in  KEY_IN_W  key beat, MSB-first
- txt_in  in  TXT_IN_W  text beat, MSB-first
- core_start  out  1  one-cycle launch pulse to core
- core_mode  out  1  registered mode_in
- core_key  out  KEY_W  assembled key
- core_data  out  DATA_W  assembled text
- core_done  in  1  core completion pulse
- core_result  in  DATA_W  valid when core_done=1
- out_valid  out  1  output beat valid
- out_ready  in  1  sink accepts beat
- out_data  out  OUT_W  result beat, MSB-first
- echo_data  out  OUT_W  matching beat of core_data, same handshake
- out_last  out  1  high on final beat
- busy  out  1  state != IDLE
- err  out  1  sticky timeout flag, cleared by next accepted start

Behaviour:
- Reset (async, low): state IDLE; all outputs 0; stored key, text and result registers 0.
- Derived constants:
  - KB = KEY_W/KEY_IN_W
  - TB = DATA_W/TXT_IN_W
  - OB = DATA_W/OUT_W
  - LB = max(KB,TB), or TB when keep_key=1
- IDLE:
  - start=1 registers mode_in and keep_key, clears err and the beat counter, and goes to LOAD.
  - start while not IDLE is ignored.
- LOAD:
  - Each cycle with in_valid=1 is one beat.
  - Key shifts left by KEY_IN_W (new beat into LSBs) while key beats < KB and keep_key=0.
  - Text shifts likewise while text beats < TB.
  - The beat counter advances only on in_valid.
  - The cycle after beat LB-1 is accepted: core_start=1 for exactly one cycle, go to RUN.
  - With defaults: 8 valid beats, core_start asserted in the cycle after the 8th beat.
- RUN:
  - Watchdog counts cycles from core_start.
  - core_done=1: capture core_result, go to UNLOAD.
  - Watchdog reaches TIMEOUT without core_done: set err, go to IDLE, no output beats.
  - core_done in the same cycle as the timeout: done wins.
- UNLOAD:
  - out_valid=1.
  - out_data = result[DATA_W-1 -: OUT_W] of the current shift position; echo_data = same slice of core_data.
  - Beat advances only when out_valid && out_ready; out_data is held stable while stalled.
  - out_last=1 on beat OB-1.
  - Handshake on the last beat: out_valid drops next cycle, go to IDLE.
- core_key/core_data are held stable from core_start through the end of UNLOAD.
- keep_key=1 right after reset reuses key 0 (legal).
- Reset asserted mid-transaction aborts immediately; no partial output after release.
- in_valid outside LOAD and core_done outside RUN are ignored.
- Elaboration error if any divisibility rule is violated.

Decomposition:
- Package simon_io_pkg:
  - state enum {IDLE, LOAD, RUN, UNLOAD}
  - beat-count width function clog2
  - default widths
- One sub-module, simon_piso: a parametrised parallel-load shift-out register with ready/valid and last flag. Instantiated twice (result, echo), sharing the handshake.

Test Plan:
- Defaults, keep_key=0, encrypt; 8 beats: key bytes 19,18,11,10,09,08,01,00 and text nibbles 6,5,6,5,6,8,7,7; core model returns c69be9bb -> core_key=1918111009080100, core_data=65656877; out_data c,6,9,b,e,9,b,b; echo 6,5,6,5,6,8,7,7; out_last on the 8th beat.
- Same load with in_valid low on alternate cycles -> identical core_key/core_data; core_start in the cycle after the 8th valid beat.
- Second transaction with keep_key=1 and text 00000000 -> core_key unchanged (1918111009080100); core_start after 8 text beats.
- out_ready toggled 1,0,0,1,... during UNLOAD -> out_data stable while stalled; exactly 8 handshakes; returns to IDLE.
- Core never asserts core_done -> err=1 after TIMEOUT cycles; busy=0; out_valid never 1; next start clears err.
- reset pulled low during the 4th output beat -> all outputs 0 immediately; IDLE after release; a later full transaction is correct.

Source files
------------

// File: rtl/simon_io_pkg.sv
// Shared types and defaults for the Simon 32/64 stream load/unload path.
package simon_io_pkg;

  typedef enum logic [1:0] {IDLE, LOAD, RUN, UNLOAD} state_t;

  localparam int DEF_DATA_W   = 32;
  localparam int DEF_KEY_W    = 64;
  localparam int DEF_KEY_IN_W = 8;
  localparam int DEF_TXT_IN_W = 4;
  localparam int DEF_OUT_W    = 4;
  localparam int DEF_TIMEOUT  = 255;

  // Bits needed to index 0..v-1, never less than 1.
  function automatic int clog2(input int v);
    int r;
    r = 0;
    while ((1 << r) < v) r++;
    return (r == 0) ? 1 : r;
  endfunction

endpackage

// File: rtl/simon_piso.sv
// Parallel-load shift-out register, MSB-first beats, ready/valid with last flag.
module simon_piso
  import simon_io_pkg::*;
#(
  parameter int W  = DEF_DATA_W,
  parameter int BW = DEF_OUT_W
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          load,
  input  logic [W-1:0]  din,
  input  logic          ready,
  output logic          valid,
  output logic [BW-1:0] dout,
  output logic          last
);
  localparam int N  = W / BW;
  localparam int CW = clog2(N + 1);
  localparam logic [CW-1:0] LAST_C = CW'(N - 1);

  logic [W-1:0]  sh;
  logic [CW-1:0] cnt;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sh    <= '0;
      cnt   <= '0;
      valid <= 1'b0;
    end else if (load) begin
      sh    <= din;
      cnt   <= '0;
      valid <= 1'b1;
    end else if (valid && ready) begin
      if (cnt == LAST_C) begin
        valid <= 1'b0;
      end else begin
        sh  <= sh << BW;
        cnt <= cnt + 1'b1;
      end
    end
  end

  assign dout = sh[W-1 -: BW];
  assign last = valid && (cnt == LAST_C);

endmodule

// File: rtl/simon_stream_io.sv
// Narrow-pin key/text deserialiser, cipher-core launcher with watchdog,
// and result/echo streamer for the Simon 32/64 core.
module simon_stream_io
  import simon_io_pkg::*;
#(
  parameter int DATA_W   = DEF_DATA_W,
  parameter int KEY_W    = DEF_KEY_W,
  parameter int KEY_IN_W = DEF_KEY_IN_W,
  parameter int TXT_IN_W = DEF_TXT_IN_W,
  parameter int OUT_W    = DEF_OUT_W,
  parameter int TIMEOUT  = DEF_TIMEOUT
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                start,
  input  logic                keep_key,
  input  logic                mode_in,
  input  logic                in_valid,
  input  logic [KEY_IN_W-1:0] key_in,
  input  logic [TXT_IN_W-1:0] txt_in,
  output logic                core_start,
  output logic                core_mode,
  output logic [KEY_W-1:0]    core_key,
  output logic [DATA_W-1:0]   core_data,
  input  logic                core_done,
  input  logic [DATA_W-1:0]   core_result,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [OUT_W-1:0]    out_data,
  output logic [OUT_W-1:0]    echo_data,
  output logic                out_last,
  output logic                busy,
  output logic                err
);
  localparam int KB  = KEY_W / KEY_IN_W;
  localparam int TB  = DATA_W / TXT_IN_W;
  localparam int LBM = (KB > TB) ? KB : TB;
  localparam int CW  = clog2(LBM + 1);
  localparam int WW  = clog2(TIMEOUT + 1);

  localparam logic [CW-1:0] KB_C      = CW'(KB);
  localparam logic [CW-1:0] TB_C      = CW'(TB);
  localparam logic [CW-1:0] LAST_FULL = CW'(LBM - 1);
  localparam logic [CW-1:0] LAST_TXT  = CW'(TB - 1);
  localparam logic [WW-1:0] WD_LAST   = WW'(TIMEOUT - 1);

  if (KEY_W % KEY_IN_W != 0) begin : g_key_chk
    $error("KEY_IN_W must divide KEY_W");
  end
  if (DATA_W % TXT_IN_W != 0) begin : g_txt_chk
    $error("TXT_IN_W must divide DATA_W");
  end
  if (DATA_W % OUT_W != 0) begin : g_out_chk
    $error("OUT_W must divide DATA_W");
  end

  state_t        state;
  logic          keep_r;
  logic [CW-1:0] cnt;
  logic [WW-1:0] wd;
  logic [CW-1:0] lb_last;
  logic          load_out;
  logic          v_res, v_echo, l_res, l_echo;

  assign lb_last  = keep_r ? LAST_TXT : LAST_FULL;
  assign load_out = (state == RUN) && core_done;
  assign busy     = (state != IDLE);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= IDLE;
      keep_r     <= 1'b0;
      core_mode  <= 1'b0;
      core_start <= 1'b0;
      core_key   <= '0;
      core_data  <= '0;
      cnt        <= '0;
      wd         <= '0;
      err        <= 1'b0;
    end else begin
      core_start <= 1'b0;
      case (state)
        IDLE: if (start) begin
          core_mode <= mode_in;
          keep_r    <= keep_key;
          err       <= 1'b0;
          cnt       <= '0;
          state     <= LOAD;
        end
        LOAD: if (in_valid) begin
          if (!keep_r && cnt < KB_C) core_key  <= (core_key << KEY_IN_W) | KEY_W'(key_in);
          if (cnt < TB_C)            core_data <= (core_data << TXT_IN_W) | DATA_W'(txt_in);
          cnt <= cnt + 1'b1;
          if (cnt == lb_last) begin
            core_start <= 1'b1;
            wd         <= '0;
            state      <= RUN;
          end
        end
        // done beats the watchdog when both land in the same cycle
        RUN: if (core_done) begin
          state <= UNLOAD;
        end else if (wd == WD_LAST) begin
          err   <= 1'b1;
          state <= IDLE;
        end else begin
          wd <= wd + 1'b1;
        end
        UNLOAD: if (out_valid && out_ready && out_last) state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  simon_piso #(.W(DATA_W), .BW(OUT_W)) u_res (
    .clk(clk), .reset(reset), .load(load_out), .din(core_result),
    .ready(out_ready), .valid(v_res), .dout(out_data), .last(l_res)
  );

  simon_piso #(.W(DATA_W), .BW(OUT_W)) u_echo (
    .clk(clk), .reset(reset), .load(load_out), .din(core_data),
    .ready(out_ready), .valid(v_echo), .dout(echo_data), .last(l_echo)
  );

  // Both shifters step in lockstep; AND keeps every output observed.
  assign out_valid = v_res & v_echo;
  assign out_last  = l_res & l_echo;

endmodule
